csi_rx_packet_decoder: RTL and testbench
========================================

CSI_RX_PACKET_DECODER -- requirements
Module: csi_rx_packet_decoder

Interface
REQ-001 SHALL have parameter VC, default 2'h0: the virtual channel accepted; packets on any other VC are dropped silently.
REQ-002 SHALL have parameter EXP_ECC, default 8'hCC: the expected header ECC byte.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port rx_hs_active, input, 1: HS burst envelope from the D-PHY lane.
REQ-006 SHALL have port rx_valid, input, 1: rx_byte is valid this cycle; only sampled while rx_hs_active=1.
REQ-007 SHALL have port rx_byte, input, 8: the deserialized lane byte.
REQ-008 SHALL have port pix_valid, output, 1: pix_data is valid this cycle.
REQ-009 SHALL have port pix_data, output, 14: the RAW14 pixel.
REQ-010 SHALL have ports line_start and line_end, output, 1 each: asserted with the first and last pixel of a line.
REQ-011 SHALL have ports frame_start and frame_end, output, 1 each: 1-cycle pulses on a valid FS or FE short packet.
REQ-012 SHALL have port frame_num, output, 16: WC field of the last FS packet.
REQ-013 SHALL have port err, output, 6: 1-cycle pulses, bits {crc, trunc, wc, dt, ecc, sync}.

Function
REQ-014 SHALL implement FSM states IDLE, SYNC, HDR, PAYLOAD, CRC and SKIP.
- IDLE->SYNC on the rising edge of rx_hs_active.
- Any state returns to IDLE when rx_hs_active=0.
REQ-015 In SYNC, the first valid byte SHALL equal 8'hB8 (HS_SYNC_SEQUENCE); then go to HDR, otherwise pulse err[0] and go to SKIP.
REQ-016 HDR SHALL capture 4 bytes: {VC[1:0],DT[5:0]}, WC[7:0], WC[15:8], ECC.
REQ-017 If ECC differs from EXP_ECC, SHALL pulse err[1] and go to SKIP.
REQ-018 Short packets SHALL be handled as follows:
- DT=6'h00: frame_num<=WC, pulse frame_start.
- DT=6'h01: pulse frame_end.
- In both cases, return to SYNC to await the next burst.
REQ-019 For DT=6'h2D, SHALL go to PAYLOAD.
- WC=0 or WC mod 7 != 0: pulse err[3] and go to SKIP.
REQ-020 Any other DT SHALL pulse err[2] and go to SKIP.
REQ-021 PAYLOAD SHALL consume WC bytes in 7-byte groups. Pixel Pn = {Bn, lsbn}, where:
- lsb1 = B4[5:0]
- lsb2 = {B5[3:0],B4[7:6]}
- lsb3 = {B6[1:0],B5[7:4]}
- lsb4 = B6[7:2]
REQ-022 A completed group SHALL be copied to a 4-pixel holding register, and P1..P4 SHALL be emitted on 4 consecutive cycles starting 1 cycle after B6 is accepted.
- At 1 byte/cycle the holding register SHALL never be overwritten before it is drained.
REQ-023 line_start SHALL accompany the first pixel of the packet, and line_end SHALL accompany P4 of the last group.
REQ-024 CRC state SHALL consume 2 bytes, LSB first, then return to SYNC.
REQ-025 SKIP SHALL ignore all bytes until rx_hs_active=0.
REQ-026 If rx_hs_active falls in HDR, PAYLOAD or CRC, SHALL pulse err[4], abort output of the partial group, and clear the byte counters.
- Pixels already in the holding register SHALL still be drained.
REQ-027 Cycles with rx_valid=0 SHALL stall the counters without error.
- WC counter: 16-bit, counts down.
- Group counter: 0..6, wraps.

Reset
REQ-028 While rst=1, SHALL hold: state=IDLE, all counters 0, pix_valid=0, pix_data=0, line_start=0, line_end=0, frame_start=0, frame_end=0, frame_num=0, err=0.
REQ-029 Assertion of rst mid-packet SHALL discard all pending pixels; after release, decoding SHALL start only on the next rx_hs_active rising edge.

Configuration
REQ-030 With CSI_RX_CRC_CHECK_EN defined, SHALL compute the payload CRC-16: polynomial x^16+x^12+x^5+1, reflected (LSB-first), initial value 16'hFFFF.
- On mismatch, SHALL pulse err[5] one cycle after the second CRC byte.
- Already-emitted pixels are not retracted.
REQ-031 Without CSI_RX_CRC_CHECK_EN, CRC bytes SHALL be consumed and ignored, and err[5] SHALL be constant 0.

Structure
REQ-032 The FSM state enum, the DT constants (FS/FE/RAW14) and the sync byte SHALL come from csi_param_pkg.
REQ-033 A sub-module csi_rx_crc16 (byte-wide CRC update, clear/enable) SHALL be instantiated only under CSI_RX_CRC_CHECK_EN.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- FS burst B8,00,05,00,CC -> frame_start pulse, frame_num=16'h0005, err=0.
- RAW14 line: WC=28 (16 pixels), pixel values 0..15 packed, valid CRC -> 16 pix_valid cycles with data 0..15, line_start with 0, line_end with 15.
- Header ECC=8'h00 -> err[1] pulse, no pixels, next burst decoded normally.
- First byte 8'hB9 -> err[0] pulse; WC=27 -> err[3] pulse.
- rx_hs_active dropped after 10 payload bytes -> exactly 4 pixels output, then err[4].
- With CSI_RX_CRC_CHECK_EN, one corrupted CRC byte -> err[5] pulse; without the macro -> err=0.

Source files
------------

// File: rtl/csi_param_pkg.sv
// +-----------------------------------------------------------------------+
// | csi_param_pkg : shared FSM state type and CSI-2 constants for RX     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package csi_param_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    HDR     = 3'd2,
    PAYLOAD = 3'd3,
    CRC     = 3'd4,
    SKIP    = 3'd5
  } state_e;

  localparam logic [5:0]  c_DT_FS         = 6'h00;
  localparam logic [5:0]  c_DT_FE         = 6'h01;
  localparam logic [5:0]  c_DT_RAW14      = 6'h2D;
  localparam logic [7:0]  c_SYNC_BYTE     = 8'hB8;
  localparam logic [15:0] c_CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] c_CRC_POLY_REFL = 16'h8408;

  // A RAW14 line must hold a whole, non-empty number of 7-byte groups.
  function automatic logic raw14_wc_ok(input logic [15:0] wc);
    return (wc != 16'd0) && ((wc % 16'd7) == 16'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csi_rx_crc16.sv
// +-----------------------------------------------------------------------+
// | csi_rx_crc16 : byte-wide reflected CRC-16 (x^16+x^12+x^5+1)          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module csi_rx_crc16
  import csi_param_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ c_CRC_POLY_REFL;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        crc_q <= c_CRC_INIT;
    else if (clr_i) crc_q <= c_CRC_INIT;
    else if (en_i)  crc_q <= crc_byte(crc_q, data_i);
  end

  assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/csi_rx_packet_decoder.sv
// +-----------------------------------------------------------------------+
// | csi_rx_packet_decoder : CSI-2 RX header/RAW14 payload decoder        |
// | Optional: CSI_RX_CRC_CHECK_EN enables the payload CRC-16 check        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module csi_rx_packet_decoder
  import csi_param_pkg::*;
#(
  parameter logic [1:0] VC      = 2'h0,
  parameter logic [7:0] EXP_ECC = 8'hCC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_hs_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        pix_valid,
  output logic [13:0] pix_data,
  output logic        line_start,
  output logic        line_end,
  output logic        frame_start,
  output logic        frame_end,
  output logic [15:0] frame_num,
  output logic [5:0]  err
);

  state_e            state_q, state_d;
  logic              hs_prev_q;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [7:0]        dt_q, dt_d;
  logic [7:0]        wc_lo_q, wc_lo_d;
  logic [15:0]       wc_cnt_q, wc_cnt_d;
  logic [2:0]        grp_cnt_q, grp_cnt_d;
  logic [5:0][7:0]   grp_q, grp_d;
  logic [3:0][13:0]  hold_q, hold_d;
  logic [2:0]        hold_cnt_q, hold_cnt_d;
  logic              hold_first_q, hold_first_d;
  logic              hold_last_q, hold_last_d;
  logic              first_grp_q, first_grp_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end_q, frame_end_d;
  logic [15:0]       frame_num_q, frame_num_d;
  logic [5:0]        err_q, err_d;

`ifdef CSI_RX_CRC_CHECK_EN
  logic              crc_clr, crc_en;
  logic [15:0]       crc_val;
  logic [7:0]        crc_lo_q, crc_lo_d;

  csi_rx_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .data_i (rx_byte),
    .crc_o  (crc_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_lo_q <= 8'h00;
    else     crc_lo_q <= crc_lo_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      // Treat reset as "already high" so a burst in flight at release is ignored.
      hs_prev_q     <= 1'b1;
      hdr_cnt_q     <= '0;
      dt_q          <= '0;
      wc_lo_q       <= '0;
      wc_cnt_q      <= '0;
      grp_cnt_q     <= '0;
      grp_q         <= '0;
      hold_q        <= '0;
      hold_cnt_q    <= '0;
      hold_first_q  <= 1'b0;
      hold_last_q   <= 1'b0;
      first_grp_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_num_q   <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= rx_hs_active;
      hdr_cnt_q     <= hdr_cnt_d;
      dt_q          <= dt_d;
      wc_lo_q       <= wc_lo_d;
      wc_cnt_q      <= wc_cnt_d;
      grp_cnt_q     <= grp_cnt_d;
      grp_q         <= grp_d;
      hold_q        <= hold_d;
      hold_cnt_q    <= hold_cnt_d;
      hold_first_q  <= hold_first_d;
      hold_last_q   <= hold_last_d;
      first_grp_q   <= first_grp_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_num_q   <= frame_num_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    dt_d          = dt_q;
    wc_lo_d       = wc_lo_q;
    wc_cnt_d      = wc_cnt_q;
    grp_cnt_d     = grp_cnt_q;
    grp_d         = grp_q;
    hold_d        = hold_q;
    hold_cnt_d    = hold_cnt_q;
    hold_first_d  = hold_first_q;
    hold_last_d   = hold_last_q;
    first_grp_d   = first_grp_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    frame_num_d   = frame_num_q;
    err_d         = '0;
`ifdef CSI_RX_CRC_CHECK_EN
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
    crc_lo_d      = crc_lo_q;
`endif

    // Drain continues regardless of the burst state; a new group load below wins.
    if (hold_cnt_q != 3'd0) begin
      hold_cnt_d = hold_cnt_q - 3'd1;
      hold_d     = {14'd0, hold_q[3:1]};
    end

    if (!rx_hs_active) begin
      if (state_q inside {HDR, PAYLOAD, CRC}) err_d[4] = 1'b1;
      state_d   = IDLE;
      hdr_cnt_d = '0;
      wc_cnt_d  = '0;
      grp_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (!hs_prev_q) state_d = SYNC;
        SYNC: if (rx_valid) begin
          hdr_cnt_d = '0;
          if (rx_byte == c_SYNC_BYTE) state_d = HDR;
          else begin
            err_d[0] = 1'b1;
            state_d  = SKIP;
          end
        end
        HDR: if (rx_valid) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd0: dt_d     = rx_byte;
            2'd1: wc_lo_d  = rx_byte;
            2'd2: wc_cnt_d = {rx_byte, wc_lo_q};
            default: begin
              wc_cnt_d = '0;
              state_d  = SKIP;
              if (rx_byte != EXP_ECC) err_d[1] = 1'b1;
              else if (dt_q[7:6] == VC) begin
                case (dt_q[5:0])
                  c_DT_FS: begin
                    frame_num_d   = wc_cnt_q;
                    frame_start_d = 1'b1;
                    state_d       = SYNC;
                  end
                  c_DT_FE: begin
                    frame_end_d = 1'b1;
                    state_d     = SYNC;
                  end
                  c_DT_RAW14: begin
                    if (raw14_wc_ok(wc_cnt_q)) begin
                      wc_cnt_d    = wc_cnt_q;
                      grp_cnt_d   = '0;
                      first_grp_d = 1'b1;
                      state_d     = PAYLOAD;
`ifdef CSI_RX_CRC_CHECK_EN
                      crc_clr     = 1'b1;
`endif
                    end else err_d[3] = 1'b1;
                  end
                  default: err_d[2] = 1'b1;
                endcase
              end
            end
          endcase
        end
        PAYLOAD: if (rx_valid) begin
`ifdef CSI_RX_CRC_CHECK_EN
          crc_en   = 1'b1;
`endif
          wc_cnt_d = wc_cnt_q - 16'd1;
          if (grp_cnt_q == 3'd6) begin
            grp_cnt_d    = '0;
            hold_d[0]    = {grp_q[0], grp_q[4][5:0]};
            hold_d[1]    = {grp_q[1], grp_q[5][3:0], grp_q[4][7:6]};
            hold_d[2]    = {grp_q[2], rx_byte[1:0], grp_q[5][7:4]};
            hold_d[3]    = {grp_q[3], rx_byte[7:2]};
            hold_cnt_d   = 3'd4;
            hold_first_d = first_grp_q;
            hold_last_d  = (wc_cnt_q == 16'd1);
            first_grp_d  = 1'b0;
          end else begin
            grp_d[grp_cnt_q] = rx_byte;
            grp_cnt_d        = grp_cnt_q + 3'd1;
          end
          if (wc_cnt_q == 16'd1) begin
            hdr_cnt_d = '0;
            state_d   = CRC;
          end
        end
        CRC: if (rx_valid) begin
          if (hdr_cnt_q == 2'd0) begin
            hdr_cnt_d = 2'd1;
`ifdef CSI_RX_CRC_CHECK_EN
            crc_lo_d  = rx_byte;
`endif
          end else begin
            hdr_cnt_d = '0;
            state_d   = SYNC;
`ifdef CSI_RX_CRC_CHECK_EN
            if ({rx_byte, crc_lo_q} != crc_val) err_d[5] = 1'b1;
`endif
          end
        end
        SKIP: state_d = SKIP;
        default: state_d = IDLE;
      endcase
    end
  end

  assign pix_valid   = (hold_cnt_q != 3'd0);
  assign pix_data    = pix_valid ? hold_q[0] : 14'd0;
  assign line_start  = pix_valid && hold_first_q && (hold_cnt_q == 3'd4);
  assign line_end    = pix_valid && hold_last_q && (hold_cnt_q == 3'd1);
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign frame_num   = frame_num_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_csi_rx_packet_decoder.sv
// +-----------------------------------------------------------------------+
// | tb_csi_rx_packet_decoder : directed self-checking bench for decoder  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_csi_rx_packet_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_hs_active;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        pix_valid;
  logic [13:0] pix_data;
  logic        line_start, line_end, frame_start, frame_end;
  logic [15:0] frame_num;
  logic [5:0]  err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int b6_cyc = 0;

`ifdef CSI_RX_CRC_CHECK_EN
  localparam int c_EXP_CRC_ERR = 1;
`else
  localparam int c_EXP_CRC_ERR = 0;
`endif

  // monitor-owned logs
  logic [13:0] pix_log[$];
  int          pix_cyc[$];
  int          ls_cnt = 0, le_cnt = 0, fs_cnt = 0, fe_cnt = 0;
  logic [13:0] ls_val = '0, le_val = '0;
  int          err_cnt[6];

  // scenario baselines
  int b_pix, b_ls, b_le, b_fs, b_fe;
  int b_err[6];

  logic [13:0] px[16];

  csi_rx_packet_decoder #(.VC(2'h0), .EXP_ECC(8'hCC)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_hs_active (rx_hs_active),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .line_start   (line_start),
    .line_end     (line_end),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .frame_num    (frame_num),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        pix_log.push_back(pix_data);
        pix_cyc.push_back(cyc);
      end
      if (line_start) begin ls_cnt++; ls_val = pix_data; end
      if (line_end)   begin le_cnt++; le_val = pix_data; end
      if (frame_start) fs_cnt++;
      if (frame_end)   fe_cnt++;
      for (int i = 0; i < 6; i++) if (err[i]) err_cnt[i]++;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_pix = pix_log.size();
    b_ls = ls_cnt; b_le = le_cnt; b_fs = fs_cnt; b_fe = fe_cnt;
    for (int i = 0; i < 6; i++) b_err[i] = err_cnt[i];
  endtask

  function automatic int err_d(input int b);
    return err_cnt[b] - b_err[b];
  endfunction

  function automatic int err_tot();
    int s = 0;
    for (int i = 0; i < 6; i++) s += err_cnt[i] - b_err[i];
    return s;
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r = c;
    for (int i = 0; i < 8; i++) begin
      logic fb = r[0] ^ d[i];
      r = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic burst_on();
    rx_hs_active = 1'b1;
    rx_valid     = 1'b0;
    tick();
  endtask

  task automatic burst_off();
    rx_hs_active = 1'b0;
    rx_valid     = 1'b0;
    repeat (6) tick();
  endtask

  task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
    send(8'hB8);
    send(di);
    send(wc[7:0]);
    send(wc[15:8]);
    send(ecc);
  endtask

  // RAW14 long packet from px[]; stops after max_bytes payload bytes
  task automatic send_line(input int ngrp, input int max_bytes, input logic [7:0] crc_xor, input bit stall);
    logic [15:0] crc;
    logic [7:0]  gb[7];
    logic [13:0] p0, p1, p2, p3;
    int          sent;
    crc  = 16'hFFFF;
    sent = 0;
    send_hdr(8'h2D, 16'(7 * ngrp), 8'hCC);
    for (int g = 0; g < ngrp; g++) begin
      p0 = px[4*g]; p1 = px[4*g+1]; p2 = px[4*g+2]; p3 = px[4*g+3];
      gb[0] = p0[13:6];
      gb[1] = p1[13:6];
      gb[2] = p2[13:6];
      gb[3] = p3[13:6];
      gb[4] = {p1[1:0], p0[5:0]};
      gb[5] = {p2[3:0], p1[5:2]};
      gb[6] = {p3[5:0], p2[5:4]};
      for (int j = 0; j < 7; j++) begin
        if (sent == max_bytes) return;
        if (stall && j == 3) repeat (2) tick();
        crc = crc_step(crc, gb[j]);
        send(gb[j]);
        sent++;
        if (g == 0 && j == 6) b6_cyc = cyc;
      end
    end
    send(crc[7:0] ^ crc_xor);
    send(crc[15:8]);
  endtask

  initial begin
    rst = 1'b1; rx_hs_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_pix_valid", 32'(pix_valid), 32'd0);
    check_value("rst_pix_data", 32'(pix_data), 32'd0);
    check_value("rst_line_flags", {30'd0, line_start, line_end}, 32'd0);
    check_value("rst_frame_flags", {30'd0, frame_start, frame_end}, 32'd0);
    check_value("rst_frame_num", 32'(frame_num), 32'd0);
    check_value("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // frame start / frame end short packets
    snap(); burst_on(); send_hdr(8'h00, 16'h0005, 8'hCC); burst_off();
    check_value("fs_pulse", fs_cnt - b_fs, 1);
    check_value("fs_frame_num", 32'(frame_num), 32'h0005);
    check_value("fs_err", err_tot(), 0);

    snap(); burst_on(); send_hdr(8'h01, 16'h0000, 8'hCC); burst_off();
    check_value("fe_pulse", fe_cnt - b_fe, 1);
    check_value("fe_no_fs", fs_cnt - b_fs, 0);
    check_value("fe_frame_num_kept", 32'(frame_num), 32'h0005);

    // other virtual channel is dropped silently
    snap(); burst_on(); send_hdr(8'h40, 16'h0009, 8'hCC); burst_off();
    check_value("vc_no_fs", fs_cnt - b_fs, 0);
    check_value("vc_frame_num", 32'(frame_num), 32'h0005);
    check_value("vc_err", err_tot(), 0);

    // 16-pixel RAW14 line, values 0..15
    for (int i = 0; i < 16; i++) px[i] = 14'(i);
    snap(); burst_on(); send_line(4, 1000, 8'h00, 1'b0); burst_off();
    check_value("line_pix_count", pix_log.size() - b_pix, 16);
    for (int i = 0; i < 16; i++)
      if (b_pix + i < pix_log.size()) check_value($sformatf("line_pix%0d", i), 32'(pix_log[b_pix+i]), i);
    if (b_pix < pix_cyc.size()) check_value("line_p1_latency", pix_cyc[b_pix], b6_cyc);
    check_value("line_ls_count", ls_cnt - b_ls, 1);
    check_value("line_ls_data", 32'(ls_val), 32'd0);
    check_value("line_le_count", le_cnt - b_le, 1);
    check_value("line_le_data", 32'(le_val), 32'd15);
    check_value("line_err", err_tot(), 0);

    // one group, wide values, with rx_valid stalls
    px[0] = 14'h3FFF; px[1] = 14'h1234; px[2] = 14'h2ABC; px[3] = 14'h0001;
    snap(); burst_on(); send_line(1, 1000, 8'h00, 1'b1); burst_off();
    check_value("stall_pix_count", pix_log.size() - b_pix, 4);
    for (int i = 0; i < 4; i++)
      if (b_pix + i < pix_log.size()) check_value($sformatf("stall_pix%0d", i), 32'(pix_log[b_pix+i]), 32'(px[i]));
    check_value("stall_ls_le", (ls_cnt - b_ls) * 16 + (le_cnt - b_le), 17);
    check_value("stall_err", err_tot(), 0);

    // bad header ECC, then normal burst
    snap(); burst_on(); send_hdr(8'h2D, 16'd28, 8'h00); repeat (7) send(8'h55); burst_off();
    check_value("ecc_err1", err_d(1), 1);
    check_value("ecc_err_total", err_tot(), 1);
    check_value("ecc_no_pix", pix_log.size() - b_pix, 0);
    snap(); burst_on(); send_hdr(8'h00, 16'h0007, 8'hCC); burst_off();
    check_value("after_ecc_fs", fs_cnt - b_fs, 1);
    check_value("after_ecc_frame_num", 32'(frame_num), 32'h0007);

    // bad sync byte
    snap(); burst_on(); send(8'hB9); send(8'h00); burst_off();
    check_value("sync_err0", err_d(0), 1);
    check_value("sync_err_total", err_tot(), 1);

    // word count not a multiple of 7
    snap(); burst_on(); send_hdr(8'h2D, 16'd27, 8'hCC); repeat (4) send(8'h11); burst_off();
    check_value("wc_err3", err_d(3), 1);
    check_value("wc_err_total", err_tot(), 1);
    check_value("wc_no_pix", pix_log.size() - b_pix, 0);

    // unsupported data type
    snap(); burst_on(); send_hdr(8'h12, 16'd7, 8'hCC); burst_off();
    check_value("dt_err2", err_d(2), 1);
    check_value("dt_err_total", err_tot(), 1);

    // burst drops after 10 payload bytes
    for (int i = 0; i < 16; i++) px[i] = 14'(i);
    snap(); burst_on(); send_line(4, 10, 8'h00, 1'b0); burst_off();
    check_value("trunc_pix_count", pix_log.size() - b_pix, 4);
    for (int i = 0; i < 4; i++)
      if (b_pix + i < pix_log.size()) check_value($sformatf("trunc_pix%0d", i), 32'(pix_log[b_pix+i]), i);
    check_value("trunc_err4", err_d(4), 1);
    check_value("trunc_err_total", err_tot(), 1);
    check_value("trunc_no_le", le_cnt - b_le, 0);

    // corrupted CRC low byte
    snap(); burst_on(); send_line(1, 1000, 8'h01, 1'b0); burst_off();
    check_value("crc_pix_count", pix_log.size() - b_pix, 4);
    check_value("crc_err5", err_d(5), c_EXP_CRC_ERR);
    check_value("crc_err_total", err_tot(), c_EXP_CRC_ERR);

    // reset mid-packet discards pending pixels, waits for a new burst
    snap(); burst_on(); send_line(2, 7, 8'h00, 1'b0);
    rst = 1'b1;
    #2;
    check_value("midrst_pix_valid", 32'(pix_valid), 32'd0);
    tick(); tick();
    rst = 1'b0;
    send_hdr(8'h00, 16'h0033, 8'hCC);
    burst_off();
    check_value("midrst_no_pix", pix_log.size() - b_pix, 0);
    check_value("midrst_no_fs", fs_cnt - b_fs, 0);
    check_value("midrst_frame_num", 32'(frame_num), 32'h0000);
    check_value("midrst_err", err_tot(), 0);
    snap(); burst_on(); send_hdr(8'h00, 16'h0042, 8'hCC); burst_off();
    check_value("postrst_fs", fs_cnt - b_fs, 1);
    check_value("postrst_frame_num", 32'(frame_num), 32'h0042);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
